// File: rtl/arena_pkg.sv
`default_nettype none
// arena_pkg: grid geometry, FSM encoding, player palette and shared cell helpers for arena_compositor.
package arena_pkg;

  localparam int GRID_W     = 80;
  localparam int GRID_H     = 60;
  localparam int CELL_SHIFT = 3;
  localparam int H_ACTIVE   = 640;
  localparam int V_ACTIVE   = 480;
  localparam int GRID_CELLS = GRID_W * GRID_H;
  localparam int ADDR_W     = 13;
  localparam int CELL_W     = 3;

  typedef logic [2:0] state_t;
  localparam state_t ST_CLEAR = 3'd0;
  localparam state_t ST_IDLE  = 3'd1;
  localparam state_t ST_RD    = 3'd2;
  localparam state_t ST_WR    = 3'd3;
  localparam state_t ST_DONE  = 3'd4;

  function automatic logic [23:0] player_colour(input logic [2:0] idx);
    case (idx)
      3'd0:    return 24'hFFFF00;
      3'd1:    return 24'h00FFFF;
      3'd2:    return 24'hFF00FF;
      3'd3:    return 24'h00FF00;
      3'd4:    return 24'h0080FF;
      3'd5:    return 24'hFF8000;
      3'd6:    return 24'h8000FF;
      default: return 24'h000000;
    endcase
  endfunction

  function automatic logic [ADDR_W-1:0] cell_addr(input logic [6:0] cx, input logic [6:0] cy);
    return ADDR_W'(cy) * ADDR_W'(GRID_W) + ADDR_W'(cx);
  endfunction

  function automatic logic is_border(input logic [6:0] cx, input logic [6:0] cy, input int bc);
    return (int'(cx) < bc) || (int'(cx) >= GRID_W - bc) ||
           (int'(cy) < bc) || (int'(cy) >= GRID_H - bc);
  endfunction

endpackage
`default_nettype wire

// File: rtl/arena_compositor_if.sv
`default_nettype none
// arena_compositor_if: control, head, pixel-coordinate and colour/status bundle of arena_compositor.
interface arena_compositor_if #(
  parameter int NUM_PLAYERS = 2
);
  logic                       reiniciar;
  logic                       step;
  logic [7*NUM_PLAYERS-1:0]   head_x;
  logic [6*NUM_PLAYERS-1:0]   head_y;
  logic [9:0]                 next_x;
  logic [9:0]                 next_y;
  logic [7:0]                 OUT_R;
  logic [7:0]                 OUT_G;
  logic [7:0]                 OUT_B;
  logic [NUM_PLAYERS-1:0]     crash;
  logic                       busy;
  logic                       step_done;

  modport master (
    output reiniciar, step, head_x, head_y, next_x, next_y,
    input  OUT_R, OUT_G, OUT_B, crash, busy, step_done
  );

  modport slave (
    input  reiniciar, step, head_x, head_y, next_x, next_y,
    output OUT_R, OUT_G, OUT_B, crash, busy, step_done
  );
endinterface
`default_nettype wire

// File: rtl/arena_grid_ram.sv
`default_nettype none
// arena_grid_ram: 4800x3 true dual-port synchronous RAM; port A read-only, port B read/write.
module arena_grid_ram
  import arena_pkg::*;
(
  input  logic              clk,
  input  logic              a_en,
  input  logic [ADDR_W-1:0] a_addr,
  output logic [CELL_W-1:0] a_data,
  input  logic              b_en,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [CELL_W-1:0] b_wdata,
  output logic [CELL_W-1:0] b_rdata
);

  logic [CELL_W-1:0] mem [GRID_CELLS];

  always_ff @(posedge clk) begin
    if (a_en) begin
      a_data <= mem[a_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (b_en) begin
      if (b_we) begin
        mem[b_addr] <= b_wdata;
      end else begin
        b_rdata <= mem[b_addr];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/arena_compositor.sv
`default_nettype none
// arena_compositor: light-cycle occupancy grid, step/collision engine and 2-stage priority pixel compositor.
// Define ARENA_HEAD_HIGHLIGHT_EN to draw each live player's last written head cell in white.
module arena_compositor
  import arena_pkg::*;
#(
  parameter int NUM_PLAYERS  = 2,
  parameter int BORDER_CELLS = 2
) (
  input  logic              VGA_CLK,
  input  logic              reset,
  arena_compositor_if.slave bus
);

  localparam logic [2:0]        LAST_P    = 3'(NUM_PLAYERS - 1);
  localparam logic [6:0]        X_LIM     = 7'(GRID_W);
  localparam logic [6:0]        Y_LIM     = 7'(GRID_H);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(GRID_CELLS - 1);

  state_t                 state, state_nxt;
  logic [ADDR_W-1:0]      clr_addr;
  logic [2:0]             pidx;
  logic [6:0]             lat_hx [NUM_PLAYERS];
  logic [6:0]             lat_hy [NUM_PLAYERS];
  logic [NUM_PLAYERS-1:0] crash;
  logic [NUM_PLAYERS-1:0] crash_snap;

  logic [6:0]             cur_x, cur_y;
  logic                   cur_crashed, cur_in_range, headon, hit;
  logic [ADDR_W-1:0]      cur_addr;

  logic                   a_en, b_en, b_we;
  logic [ADDR_W-1:0]      a_addr, b_addr;
  logic [CELL_W-1:0]      a_data, b_wdata, b_rdata;

  arena_grid_ram u_ram (
    .clk     (VGA_CLK),
    .a_en    (a_en),
    .a_addr  (a_addr),
    .a_data  (a_data),
    .b_en    (b_en),
    .b_we    (b_we),
    .b_addr  (b_addr),
    .b_wdata (b_wdata),
    .b_rdata (b_rdata)
  );

  always_comb begin
    cur_x       = '0;
    cur_y       = '0;
    cur_crashed = 1'b0;
    for (int q = 0; q < NUM_PLAYERS; q++) begin
      if (pidx == 3'(q)) begin
        cur_x       = lat_hx[q];
        cur_y       = lat_hy[q];
        cur_crashed = crash[q];
      end
    end
  end

  // Head-on uses the crash state from the start of the step so both colliding players fall.
  always_comb begin
    headon = 1'b0;
    for (int q = 0; q < NUM_PLAYERS; q++) begin
      if (pidx != 3'(q) && !crash_snap[q] && lat_hx[q] == cur_x && lat_hy[q] == cur_y) begin
        headon = 1'b1;
      end
    end
  end

  assign cur_in_range = (cur_x < X_LIM) && (cur_y < Y_LIM);
  assign cur_addr     = cell_addr(cur_x, cur_y);
  assign hit          = !cur_in_range || is_border(cur_x, cur_y, BORDER_CELLS) ||
                        headon || (b_rdata != '0);

  always_ff @(posedge VGA_CLK or posedge reset) begin
    if (reset) begin
      state <= ST_CLEAR;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (bus.reiniciar) begin
      state_nxt = ST_CLEAR;
    end else begin
      case (state)
        ST_CLEAR: if (clr_addr == LAST_ADDR) state_nxt = ST_IDLE;
        ST_IDLE:  if (bus.step) state_nxt = ST_RD;
        ST_RD:    state_nxt = ST_WR;
        ST_WR:    state_nxt = (pidx == LAST_P) ? ST_DONE : ST_RD;
        ST_DONE:  state_nxt = ST_IDLE;
        default:  state_nxt = ST_CLEAR;
      endcase
    end
  end

  always_comb begin
    b_en          = 1'b0;
    b_we          = 1'b0;
    b_addr        = cur_addr;
    b_wdata       = '0;
    bus.busy      = (state != ST_IDLE);
    bus.step_done = (state == ST_DONE);
    case (state)
      ST_CLEAR: begin
        b_en   = 1'b1;
        b_we   = 1'b1;
        b_addr = clr_addr;
      end
      ST_RD: b_en = cur_in_range && !bus.reiniciar;
      ST_WR: begin
        b_en    = !bus.reiniciar && !cur_crashed && !hit;
        b_we    = 1'b1;
        b_wdata = pidx + 3'd1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge VGA_CLK or posedge reset) begin
    if (reset) begin
      clr_addr   <= '0;
      pidx       <= '0;
      crash      <= '0;
      crash_snap <= '0;
      for (int q = 0; q < NUM_PLAYERS; q++) begin
        lat_hx[q] <= '0;
        lat_hy[q] <= '0;
      end
    end else if (bus.reiniciar) begin
      clr_addr <= '0;
    end else begin
      case (state)
        ST_CLEAR: begin
          if (clr_addr == LAST_ADDR) begin
            clr_addr <= '0;
            crash    <= '0;
          end else begin
            clr_addr <= clr_addr + ADDR_W'(1);
          end
        end
        ST_IDLE: begin
          if (bus.step) begin
            for (int q = 0; q < NUM_PLAYERS; q++) begin
              lat_hx[q] <= bus.head_x[7*q +: 7];
              lat_hy[q] <= {1'b0, bus.head_y[6*q +: 6]};
            end
            pidx       <= '0;
            crash_snap <= crash;
          end
        end
        ST_WR: begin
          for (int q = 0; q < NUM_PLAYERS; q++) begin
            if (pidx == 3'(q) && !crash[q] && hit) begin
              crash[q] <= 1'b1;
            end
          end
          pidx <= pidx + 3'd1;
        end
        default: ;
      endcase
    end
  end

  assign bus.crash = crash;

  logic [6:0]  pix_cx, pix_cy;
  logic        pix_visible;
  logic        s1_visible, s1_border, head_hit;
  logic [23:0] colour;

  assign pix_cx      = bus.next_x[9:CELL_SHIFT];
  assign pix_cy      = bus.next_y[9:CELL_SHIFT];
  assign pix_visible = (bus.next_x < 10'(H_ACTIVE)) && (bus.next_y < 10'(V_ACTIVE));
  assign a_en        = pix_visible;
  assign a_addr      = cell_addr(pix_cx, pix_cy);

  always_ff @(posedge VGA_CLK or posedge reset) begin
    if (reset) begin
      s1_visible <= 1'b0;
      s1_border  <= 1'b0;
    end else begin
      s1_visible <= pix_visible;
      s1_border  <= is_border(pix_cx, pix_cy, BORDER_CELLS);
    end
  end

`ifdef ARENA_HEAD_HIGHLIGHT_EN
  logic [6:0]             last_hx [NUM_PLAYERS];
  logic [6:0]             last_hy [NUM_PLAYERS];
  logic [NUM_PLAYERS-1:0] head_valid;
  logic [6:0]             s1_cx, s1_cy;

  always_ff @(posedge VGA_CLK or posedge reset) begin
    if (reset) begin
      head_valid <= '0;
      s1_cx      <= '0;
      s1_cy      <= '0;
      for (int q = 0; q < NUM_PLAYERS; q++) begin
        last_hx[q] <= '0;
        last_hy[q] <= '0;
      end
    end else begin
      s1_cx <= pix_cx;
      s1_cy <= pix_cy;
      if (state == ST_CLEAR) begin
        head_valid <= '0;
      end else if (state == ST_WR && !bus.reiniciar && !cur_crashed && !hit) begin
        for (int q = 0; q < NUM_PLAYERS; q++) begin
          if (pidx == 3'(q)) begin
            last_hx[q]    <= cur_x;
            last_hy[q]    <= cur_y;
            head_valid[q] <= 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    head_hit = 1'b0;
    for (int q = 0; q < NUM_PLAYERS; q++) begin
      if (head_valid[q] && !crash[q] && last_hx[q] == s1_cx && last_hy[q] == s1_cy) begin
        head_hit = 1'b1;
      end
    end
  end
`else
  assign head_hit = 1'b0;
`endif

  always_comb begin
    colour = 24'h000000;
    if (!s1_visible) begin
      colour = 24'h000000;
    end else if (head_hit) begin
      colour = 24'hFFFFFF;
    end else if (a_data != '0) begin
      colour = player_colour(a_data - 3'd1);
    end else if (s1_border) begin
      colour = 24'hFF0000;
    end
  end

  always_ff @(posedge VGA_CLK or posedge reset) begin
    if (reset) begin
      bus.OUT_R <= '0;
      bus.OUT_G <= '0;
      bus.OUT_B <= '0;
    end else begin
      bus.OUT_R <= colour[23:16];
      bus.OUT_G <= colour[15:8];
      bus.OUT_B <= colour[7:0];
    end
  end

endmodule
`default_nettype wire

// File: doc/arena_compositor.md
# arena_compositor

Parametrised successor to the single-player arena overlay. It keeps an 80×60 cell occupancy grid (8×8-pixel cells) of light-cycle trails for up to 7 players and runs a step engine that writes each player's new head cell and detects collisions. It also runs a 2-stage pixel pipeline that turns `next_x`/`next_y` into priority-composited RGB (head > trail > border > background); it does not XOR the layers. It sits between the per-player movement blocks and the `vga` driver.

## Interface
- `NUM_PLAYERS`, 2, number of players, legal range 1..7
- `BORDER_CELLS`, 2, border thickness in cells on every edge
- `VGA_CLK`  in  1  sole clock
- `reset`  in  1  asynchronous, active-high
- `reiniciar`  in  1  level; while high, forces a grid clear
- `step`  in  1  one-cycle pulse; samples all heads and runs one movement step
- `head_x`  in  7*NUM_PLAYERS  per-player head column; player p uses bits [7p+6:7p]
- `head_y`  in  6*NUM_PLAYERS  per-player head row; player p uses bits [6p+5:6p]
- `next_x`, `next_y`  in  10 each  coordinates of the next pixel the VGA driver will draw
- `OUT_R`, `OUT_G`, `OUT_B`  out  8 each  composited colour
- `crash`  out  NUM_PLAYERS  latched per-player crash flags
- `busy`  out  1  high while clearing or stepping
- `step_done`  out  1  one-cycle pulse when a step completes

## Operation
- Grid cell value: 0 = empty; p+1 = trail of player p. Width is 3 bits.
- FSM states are CLEAR, IDLE, RD, WR and DONE.
- **CLEAR**
  - Sweeps addresses 0..4799, writing 0 at one address per cycle.
  - When the sweep finishes, all `crash` bits clear and the FSM goes to IDLE.
  - `busy` is high throughout CLEAR.
- **IDLE**
  - A `step` pulse latches `head_x`/`head_y` and sets the player index p = 0. The FSM goes to RD.
  - `step` is ignored in every other state. A dropped step produces no `step_done`.
- **RD(p)**
  - Issues a read of cell (head_y_p*80 + head_x_p).
  - If the coordinates are out of range, the read is suppressed.
- **WR(p)**
  - Evaluates a hit when `crash[p]` is 0. A hit is any of the following:
    - the read value is nonzero;
    - head_x ≥ 80 or head_y ≥ 60;
    - the head lies in the border: x < BORDER_CELLS, x ≥ 80-BORDER_CELLS, y < BORDER_CELLS or y ≥ 60-BORDER_CELLS;
    - the latched head equals the latched head of another player q with `crash[q]` = 0 (head-on collision; both players crash).
  - On a hit, sets `crash[p]` and writes nothing.
  - With no hit, writes p+1 to the cell.
  - If `crash[p]` was already 1, does nothing, but still spends the cycle.
  - Increments p. Goes to RD if p < NUM_PLAYERS, else to DONE.
- **DONE**
  - Pulses `step_done` and goes to IDLE.
- A head that did not move reads its own trail, so it counts as a crash.
- `reiniciar` high in any state aborts the current activity and enters CLEAR at address 0. CLEAR restarts from address 0 every cycle while `reiniciar` stays high.
- **Pixel pipeline**
  - Cell = (next_x>>3, next_y>>3).
  - Stage 1: RAM read on the pixel port, with x, y and the in-border flag registered alongside.
  - Stage 2, priority order:
    1. next_x ≥ 640 or next_y ≥ 480 → black;
    2. head match (see Configuration) → white;
    3. cell nonzero → colour from the player palette;
    4. border → red (255,0,0);
    5. otherwise → black.
- The RAM is true dual-port: the pixel port is read-only, the engine port is read/write. There is no arbitration between them.

## Timing
- **Reset**
  - All of `OUT_*`, `crash`, `step_done` and the pipeline registers are 0.
  - `busy` = 1 and the FSM is in CLEAR at address 0. Reset does not clear the RAM; the sweep does.
- After reset deasserts, a full clear takes 4800 cycles. `busy` falls in the cycle after the last write.
- **Step latency**
  - `step` is sampled at cycle 0. RD/WR pairs occupy cycles 1..2N.
  - `step_done` is high in cycle 2N+1, and `busy` is high for cycles 1..2N+1.
  - `crash[p]` updates at the end of WR(p).
- **Pixel latency:** `OUT_*` reflects `next_x`/`next_y` exactly 2 cycles later.
- Same-cycle access to the same address on both RAM ports: the pixel port may return either the old or the new value. The frame is allowed one pixel of staleness.

## Configuration
- `ARENA_HEAD_HIGHLIGHT_EN` defined:
  - stage 2 compares the pixel's cell against every player's last successfully written head;
  - a match with a non-crashed player draws white (255,255,255).
- Undefined: the comparators and head registers are removed, and head cells draw in the trail palette colour.

## Structure
- Package `arena_pkg` holds:
  - GRID_W=80, GRID_H=60, CELL_SHIFT=3, H_ACTIVE=640, V_ACTIVE=480;
  - the FSM state encoding;
  - the 7-entry 24-bit player palette (entry 0 is yellow, 255,255,0).
- Sub-module `arena_grid_ram`: a 4800×3 true dual-port synchronous RAM with a read-only port A and a read/write port B.

## Test plan
- **Reset and clear:** assert `reset`, release it, and let 4800 cycles pass → `busy` falls; every on-screen pixel is black except the 16-px red border.
- **Single step, NUM_PLAYERS=2:** heads (10,10) and (20,20); `step` → `step_done` at cycle 5. Pixel (80,80) then outputs (255,255,0) after 2 cycles; `crash`=00.
- **Head-on collision:** both heads at (30,30) → `crash`=11 and the cell stays 0.
- **Border and out-of-range:** player 0 head at (1,10) and player 1 at (85,5) → `crash`=11, and both flags stay latched through a later legal step.
- **Trail hit and dropped step:** player 1 steps onto player 0's trail → `crash`=10. A `step` issued while `busy` gives no `step_done`.
- **Abort and highlight:** `reiniciar` asserted mid-step → enters CLEAR and `crash` clears after 4800 cycles. With the macro defined, the live head pixel reads (255,255,255).
